lf_ssp_tx: RTL and testbench
============================

# lf_ssp_tx

FPGA-to-ARM serial transmitter for the LF image: buffers 8-bit samples produced by an LF major mode and shifts them out MSB-first on the SSP pins (ssp_clk, ssp_frame, ssp_din). It is the return-direction counterpart of the ARM-to-FPGA command link. A mode instantiates it, feeds it samples with a valid/ready handshake, and routes its three outputs through the top-level SSP muxes.

## Interface
Parameters:
- WORD_W, 8, bits per SSP word (2..16)
- FIFO_DEPTH, 4, sample buffer depth in words (power of two, >=2)
- CLK_HALF, 4, pck0 cycles per ssp_clk half-period (>=1)

Ports:
- pck0  input  1  clock; all logic on rising edge
- nreset  input  1  asynchronous, active-low reset
- enable  input  1  allows new words to start; a word already in flight always completes
- data  input  WORD_W  sample to transmit
- data_valid  input  1  data is offered this cycle
- data_ready  output  1  FIFO can accept a word (= not full)
- clear_ovf  input  1  synchronous clear of overflow
- overflow  output  1  sticky: a word was offered while full and dropped
- level  output  clog2(FIFO_DEPTH)+1  words currently buffered
- busy  output  1  high while a word is being shifted
- ssp_clk  output  1  serial clock to ARM
- ssp_frame  output  1  high during the first (MSB) bit of each word
- ssp_din  output  1  serial data to ARM, MSB first

## Operation
- FIFO: push when data_valid && data_ready. data_ready = (level != FIFO_DEPTH), combinational from registered level. Offer while full: word dropped, FIFO unchanged, overflow set next cycle. Pop and push in same cycle: level unchanged, both take effect; data_ready is still low when full, even with a simultaneous pop.
- overflow: set on dropped word; cleared by clear_ovf; set wins over clear in the same cycle.
- State IDLE: ssp_clk=0, ssp_frame=0, ssp_din=0, busy=0. If enable && level!=0: pop head into shifter, bit index = WORD_W-1, go SHIFT.
- State SHIFT: each bit lasts 2*CLK_HALF cycles; ssp_clk low for first CLK_HALF cycles, high for next CLK_HALF. ssp_din holds the current bit for the whole bit period and changes only while ssp_clk falls (ARM samples on ssp_clk rising). ssp_frame=1 for the entire MSB bit period, 0 otherwise. busy=1.
- End of last bit (last high-phase cycle): if enable && level!=0, pop and start next word with no gap (ssp_clk falls, ssp_frame rises together); else return to IDLE.
- enable deasserted mid-word: the word finishes; no new word starts. FIFO contents are retained.
- All outputs registered; no combinational path from data/data_valid to SSP pins.

## Timing
- Reset (nreset low, asynchronous): ssp_clk=0, ssp_frame=0, ssp_din=0, busy=0, overflow=0, level=0, data_ready=1, state IDLE, FIFO pointers 0. Reset mid-word aborts immediately; buffered words are lost.
- Latency: word pushed at edge t into empty FIFO with IDLE and enable=1 → level=1 after t+1, pop at t+1, ssp_frame=1 and ssp_din=MSB after t+2, first ssp_clk rise after t+2+CLK_HALF.
- Word duration: WORD_W*2*CLK_HALF cycles (default 64). Sustained throughput one word per 64 cycles; back-to-back words have no idle cycles.
- level counter: saturates neither way; pointers wrap modulo FIFO_DEPTH.
- ssp_clk duty exactly 50%; no glitches at word boundaries or on enable changes.

## Test plan
- Reset: hold nreset low, toggle inputs → all outputs at reset values; release, push 0xA5 → ssp_din serial 1,0,1,0,0,1,0,1 sampled on 8 ssp_clk rises, ssp_frame high only for first bit, frame rises 2 cycles after push.
- Back-to-back: push 0x81, 0x7E, 0xFF, 0x00 → 32 contiguous ssp_clk periods, 4 frame pulses 64 cycles apart, bits match, level returns to 0, busy falls 1 cycle after last high phase.
- Overflow: enable=0, push 5 words → data_ready low after 4th, 5th dropped, overflow=1, level=4; assert clear_ovf and valid-while-full in same cycle → overflow stays 1; enable=1 → only first 4 words emitted.
- Enable drop mid-word: deassert enable during bit 3 of 0x3C with 2 more buffered → 0x3C completes, ssp_clk stays low afterwards, level=2; re-enable → remaining words sent in order.
- Async reset mid-word: pulse nreset low during bit 5 → ssp_clk/ssp_frame/ssp_din 0 immediately, level=0, no further activity.
- Parameter sweep: WORD_W=12, CLK_HALF=1, FIFO_DEPTH=2 → 24-cycle words, frame on 12-bit MSB, full at level 2.

Source files
------------

// File: rtl/lf_ssp_tx.sv
// LF-mode FPGA-to-ARM SSP transmitter: a small sample FIFO feeding an MSB-first
// shifter that drives ssp_clk / ssp_frame / ssp_din, all from registers.
module lf_ssp_tx #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_HALF   = 4
) (
    input  logic                        pck0,
    input  logic                        nreset,
    input  logic                        enable,
    input  logic [WORD_W-1:0]           data,
    input  logic                        data_valid,
    output logic                        data_ready,
    input  logic                        clear_ovf,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        ssp_clk,
    output logic                        ssp_frame,
    output logic                        ssp_din
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(2 * CLK_HALF);
    localparam int BIT_W = $clog2(WORD_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * CLK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(CLK_HALF);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    logic [FIFO_DEPTH-1:0][WORD_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]                  level_q, level_d;
    logic                              ovf_q, ovf_d;

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [BIT_W-1:0]                  bit_q, bit_d;
    logic [WORD_W-1:0]                 shreg_q, shreg_d;
    logic                              sclk_q, sclk_d;
    logic                              frame_q, frame_d;
    logic                              din_q, din_d;
    logic                              busy_q, busy_d;

    logic                              push, pop, start;
    logic [WORD_W-1:0]                 head;
    logic [CNT_W-1:0]                  cnt_nxt;

    assign data_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign push       = data_valid && data_ready;
    assign head       = mem_q[rd_ptr_q];
    assign start      = enable && (level_q != '0);
    assign cnt_nxt    = cnt_q + 1'b1;

    // FIFO bookkeeping; pointers wrap for free because depth is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // a drop in the same cycle as a clear must leave overflow set
        if (data_valid && !data_ready) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        frame_d = frame_q;
        din_d   = din_q;
        busy_d  = busy_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pop     = 1'b1;
                    state_d = ST_SHIFT;
                    shreg_d = head;
                    bit_d   = BIT_W'(WORD_W - 1);
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    frame_d = 1'b1;
                    din_d   = head[WORD_W-1];
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d  = cnt_nxt;
                    sclk_d = (cnt_nxt >= CNT_HIGH);
                end else if (bit_q != '0) begin
                    // next bit: data changes together with the falling ssp_clk
                    bit_d   = bit_q - 1'b1;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    frame_d = 1'b0;
                    shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                    din_d   = shreg_q[WORD_W-2];
                end else if (start) begin
                    // back-to-back word with no idle cycle between them
                    pop     = 1'b1;
                    shreg_d = head;
                    bit_d   = BIT_W'(WORD_W - 1);
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    frame_d = 1'b1;
                    din_d   = head[WORD_W-1];
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    frame_d = 1'b0;
                    din_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            sclk_q   <= 1'b0;
            frame_q  <= 1'b0;
            din_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            frame_q  <= frame_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
        end
    end

    assign overflow  = ovf_q;
    assign level     = level_q;
    assign busy      = busy_q;
    assign ssp_clk   = sclk_q;
    assign ssp_frame = frame_q;
    assign ssp_din   = din_q;

endmodule

// File: tb/tb_lf_ssp_tx.sv
// Bench for lf_ssp_tx: a serial monitor deserialises ssp_din on ssp_clk rises and
// compares each word against a scoreboard filled as words are offered.
module tb_lf_ssp_tx;

    logic        pck0 = 1'b0;
    logic        nreset = 1'b0;
    logic        enable = 1'b0, data_valid = 1'b0, clear_ovf = 1'b0;
    logic [7:0]  data = '0;
    logic        data_ready, overflow, busy, ssp_clk, ssp_frame, ssp_din;
    logic [2:0]  level;

    logic        en2 = 1'b0, dv2 = 1'b0, clr2 = 1'b0;
    logic [11:0] data2 = '0;
    logic        ready2, ovf2, busy2, sclk2, frm2, din2;
    logic [1:0]  level2;

    lf_ssp_tx dut (
        .pck0(pck0), .nreset(nreset), .enable(enable), .data(data),
        .data_valid(data_valid), .data_ready(data_ready), .clear_ovf(clear_ovf),
        .overflow(overflow), .level(level), .busy(busy), .ssp_clk(ssp_clk),
        .ssp_frame(ssp_frame), .ssp_din(ssp_din)
    );

    lf_ssp_tx #(.WORD_W(12), .FIFO_DEPTH(2), .CLK_HALF(1)) dut2 (
        .pck0(pck0), .nreset(nreset), .enable(en2), .data(data2),
        .data_valid(dv2), .data_ready(ready2), .clear_ovf(clr2),
        .overflow(ovf2), .level(level2), .busy(busy2), .ssp_clk(sclk2),
        .ssp_frame(frm2), .ssp_din(din2)
    );

    always #5 pck0 = ~pck0;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    always @(posedge pck0) cyc <= cyc + 1;

    logic [7:0] sb[$];
    int         frame_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // serial monitor for the default instance, sampled on the falling pck0 edge
    logic       prev_clk = 1'b0, prev_frame = 1'b0;
    logic [7:0] mon_word = '0;
    int         mon_bits = 0;
    always @(negedge pck0) begin
        if (!nreset) begin
            mon_bits   = 0;
            prev_clk   = 1'b0;
            prev_frame = 1'b0;
        end else begin
            if (ssp_frame && !prev_frame) frame_cyc.push_back(cyc);
            if (ssp_clk && !prev_clk) begin
                chk("frame_pos", 32'(ssp_frame), 32'(mon_bits == 0));
                mon_word = {mon_word[6:0], ssp_din};
                mon_bits++;
                if (mon_bits == 8) begin
                    if (sb.size() == 0) chk("extra_word", 32'(sb.size()), 32'd1);
                    else chk("word", 32'(mon_word), 32'(sb.pop_front()));
                    mon_bits = 0;
                end
            end
            prev_clk   = ssp_clk;
            prev_frame = ssp_frame;
        end
    end

    // called at a falling edge; the word is sampled on the next rising edge
    task automatic push_word(input logic [7:0] d, input logic acc);
        data       = d;
        data_valid = 1'b1;
        chk("ready", 32'(data_ready), 32'(acc));
        if (acc) sb.push_back(d);
        @(negedge pck0);
        data_valid = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge pck0);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frame_cyc.size() < n && k < budget) begin
            @(negedge pck0);
            k++;
        end
        chk("frames_seen", 32'(frame_cyc.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((sb.size() != 0 || busy) && k < budget) begin
            @(negedge pck0);
            k++;
        end
        chk("drain_sb", 32'(sb.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, f;
        logic [11:0] capt0, capt1;

        // reset with inputs toggling
        repeat (3) begin
            @(negedge pck0);
            data_valid = ~data_valid; enable = ~enable; clear_ovf = ~clear_ovf; data = ~data;
        end
        @(negedge pck0);
        chk("rst_clk", 32'(ssp_clk), 0);
        chk("rst_frame", 32'(ssp_frame), 0);
        chk("rst_din", 32'(ssp_din), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ready", 32'(data_ready), 1);
        data_valid = 0; enable = 0; clear_ovf = 0; data = 0;
        @(negedge pck0);
        nreset = 1'b1;
        enable = 1'b1;
        @(negedge pck0);

        // single word, latency and first clock rise
        frame_cyc.delete();
        c0 = cyc;
        push_word(8'hA5, 1);
        chk("a5_level", 32'(level), 1);
        wait_frames(1, 20);
        f = (frame_cyc.size() > 0) ? frame_cyc[0] : cyc;
        chk("a5_lat", 32'(f - c0), 2);
        chk("a5_msb", 32'(ssp_din), 1);
        wait_until(f + 3);
        chk("a5_clk_lo", 32'(ssp_clk), 0);
        @(negedge pck0);
        chk("a5_clk_hi", 32'(ssp_clk), 1);
        wait_idle(200);

        // back-to-back words
        frame_cyc.delete();
        push_word(8'h81, 1);
        push_word(8'h7E, 1);
        push_word(8'hFF, 1);
        push_word(8'h00, 1);
        wait_frames(4, 400);
        if (frame_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("b2b_gap", 32'(frame_cyc[i] - frame_cyc[i-1]), 64);
            wait_until(frame_cyc[3] + 63);
            chk("b2b_busy_last", 32'(busy), 1);
            chk("b2b_clk_last", 32'(ssp_clk), 1);
            @(negedge pck0);
            chk("b2b_busy_fall", 32'(busy), 0);
            chk("b2b_clk_fall", 32'(ssp_clk), 0);
        end
        wait_idle(400);
        chk("b2b_level", 32'(level), 0);

        // overflow with transmitter held off
        enable = 1'b0;
        frame_cyc.delete();
        push_word(8'h11, 1);
        push_word(8'h22, 1);
        push_word(8'h33, 1);
        push_word(8'h44, 1);
        push_word(8'h55, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 4);
        data = 8'h66; data_valid = 1'b1; clear_ovf = 1'b1;
        @(negedge pck0);
        data_valid = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 1);
        chk("ovf_level2", 32'(level), 4);
        @(negedge pck0);
        clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);
        enable = 1'b1;
        wait_frames(4, 400);
        wait_idle(400);
        repeat (20) @(negedge pck0);
        chk("ovf_only4", 32'(frame_cyc.size()), 4);
        chk("ovf_level_end", 32'(level), 0);

        // enable dropped during bit 3
        frame_cyc.delete();
        push_word(8'h3C, 1);
        push_word(8'h11, 1);
        push_word(8'h22, 1);
        wait_frames(1, 20);
        f = (frame_cyc.size() > 0) ? frame_cyc[0] : cyc;
        wait_until(f + 26);
        enable = 1'b0;
        wait_until(f + 64);
        chk("en_busy", 32'(busy), 0);
        chk("en_clk", 32'(ssp_clk), 0);
        chk("en_level", 32'(level), 2);
        wait_until(f + 90);
        chk("en_clk_hold", 32'(ssp_clk), 0);
        chk("en_frames", 32'(frame_cyc.size()), 1);
        chk("en_sb", 32'(sb.size()), 2);
        enable = 1'b1;
        wait_frames(3, 300);
        wait_idle(300);

        // async reset in the middle of bit 5
        frame_cyc.delete();
        push_word(8'h5A, 1);
        wait_frames(1, 20);
        f = (frame_cyc.size() > 0) ? frame_cyc[0] : cyc;
        wait_until(f + 37);
        chk("ar_pre_clk", 32'(ssp_clk), 1);
        chk("ar_pre_din", 32'(ssp_din), 1);
        #2 nreset = 1'b0;
        #1;
        chk("ar_clk", 32'(ssp_clk), 0);
        chk("ar_frame", 32'(ssp_frame), 0);
        chk("ar_din", 32'(ssp_din), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_level", 32'(level), 0);
        sb.delete();
        repeat (3) @(negedge pck0);
        nreset = 1'b1;
        frame_cyc.delete();
        repeat (60) @(negedge pck0);
        chk("ar_quiet_busy", 32'(busy), 0);
        chk("ar_quiet_frames", 32'(frame_cyc.size()), 0);

        // WORD_W=12, FIFO_DEPTH=2, CLK_HALF=1 instance
        data2 = 12'hABC; dv2 = 1'b1;
        chk("sw_rdy0", 32'(ready2), 1);
        @(negedge pck0);
        data2 = 12'h123;
        chk("sw_rdy1", 32'(ready2), 1);
        @(negedge pck0);
        data2 = 12'hFFF;
        chk("sw_rdy2", 32'(ready2), 0);
        @(negedge pck0);
        dv2 = 1'b0;
        chk("sw_level", 32'(level2), 2);
        chk("sw_ovf", 32'(ovf2), 1);
        en2 = 1'b1;
        begin
            int k = 0;
            while (!frm2 && k < 10) begin
                @(negedge pck0);
                k++;
            end
        end
        chk("sw_start", 32'(frm2), 1);
        capt0 = '0; capt1 = '0;
        for (int k = 0; k < 48; k++) begin
            chk("sw_clk", 32'(sclk2), 32'(k % 2));
            chk("sw_frm", 32'(frm2), 32'((k % 24) < 2));
            if (k % 2 == 1) begin
                if (k < 24) capt0 = {capt0[10:0], din2};
                else        capt1 = {capt1[10:0], din2};
            end
            @(negedge pck0);
        end
        chk("sw_word0", 32'(capt0), 32'h0ABC);
        chk("sw_word1", 32'(capt1), 32'h0123);
        chk("sw_busy_end", 32'(busy2), 0);
        chk("sw_level_end", 32'(level2), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
